// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//   Two-entry skid register for a pipeline boundary. The head entry ("main")
//   drives the outputs directly from flops, so there is no combinational path
//   from in_* to out_*. A second register ("skid") absorbs one extra entry
//   when downstream stalls while upstream is still sending. Order is FIFO.
//
// Optional feature (macro EPU_PIPE_PERF_EN):
//   Defined   -> adds output stall_cycles, a saturating count of cycles with
//                out_valid=1 and out_ready=0. Cleared by reset only.
//   Undefined -> no stall_cycles port and no counter.
//
// Ports
//   clk_in       in   1          clock, all state on rising edge
//   rst_in       in   1          synchronous active-high reset
//   rdy_in       in   1          global enable; low freezes everything
//   flush        in   1          discard all held entries
//   in_valid     in   1          upstream valid
//   in_ready     out  1          upstream ready
//   in_forward   in   1          upstream entry: forward flag
//   in_rd_addr   in   RD_ADDR_W  upstream entry: writeback address
//   in_rd_val    in   RD_VAL_W   upstream entry: writeback value
//   in_payload   in   PAYLOAD_W  upstream entry: opaque payload
//   out_valid    out  1          downstream valid
//   out_ready    in   1          downstream ready
//   out_forward  out  1          head entry: forward flag
//   out_rd_addr  out  RD_ADDR_W  head entry: writeback address
//   out_rd_val   out  RD_VAL_W   head entry: writeback value
//   out_payload  out  PAYLOAD_W  head entry: opaque payload
//   fwd_valid    out  1          head entry is held and carries forward=1
//   occupancy    out  2          number of held entries (0..2)
//   stall_cycles out  CNT_W      (EPU_PIPE_PERF_EN only) stall counter
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int unsigned          PAYLOAD_W     = 42,
    parameter int unsigned          RD_ADDR_W     = 5,
    parameter int unsigned          RD_VAL_W      = 32,
    parameter logic [PAYLOAD_W-1:0] RESET_PAYLOAD = '0,
    parameter int unsigned          CNT_W         = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_forward,
    input  logic [RD_ADDR_W-1:0] in_rd_addr,
    input  logic [RD_VAL_W-1:0]  in_rd_val,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_forward,
    output logic [RD_ADDR_W-1:0] out_rd_addr,
    output logic [RD_VAL_W-1:0]  out_rd_val,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 fwd_valid,
    output logic [1:0]           occupancy
`ifdef EPU_PIPE_PERF_EN
    ,
    output logic [CNT_W-1:0]     stall_cycles
`endif
);

    // Encodings equal the number of held entries so occupancy is the state.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    logic                   main_fwd_q,  main_fwd_d;
    logic [RD_ADDR_W-1:0]   main_addr_q, main_addr_d;
    logic [RD_VAL_W-1:0]    main_val_q,  main_val_d;
    logic [PAYLOAD_W-1:0]   main_pay_q,  main_pay_d;

    logic                   skid_fwd_q,  skid_fwd_d;
    logic [RD_ADDR_W-1:0]   skid_addr_q, skid_addr_d;
    logic [RD_VAL_W-1:0]    skid_val_q,  skid_val_d;
    logic [PAYLOAD_W-1:0]   skid_pay_q,  skid_pay_d;

    logic                   in_xfer;
    logic                   out_xfer;

    // Handshakes depend only on state and rdy_in, never on in_*/out_ready
    // combinationally through the data path.
    assign in_ready  = rdy_in && (state_q != ST_TWO);
    assign out_valid = rdy_in && (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_fwd_d  = main_fwd_q;
        main_addr_d = main_addr_q;
        main_val_d  = main_val_q;
        main_pay_d  = main_pay_q;
        skid_fwd_d  = skid_fwd_q;
        skid_addr_d = skid_addr_q;
        skid_val_d  = skid_val_q;
        skid_pay_d  = skid_pay_q;

        if (flush) begin
            // Flush wins over any transfer seen this cycle; clearing the
            // forward flag keeps a stale head from looking forwardable.
            state_d    = ST_EMPTY;
            main_fwd_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_fwd_d  = in_forward;
                        main_addr_d = in_rd_addr;
                        main_val_d  = in_rd_val;
                        main_pay_d  = in_payload;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer) begin
                        if (out_xfer) begin
                            main_fwd_d  = in_forward;
                            main_addr_d = in_rd_addr;
                            main_val_d  = in_rd_val;
                            main_pay_d  = in_payload;
                        end else begin
                            skid_fwd_d  = in_forward;
                            skid_addr_d = in_rd_addr;
                            skid_val_d  = in_rd_val;
                            skid_pay_d  = in_payload;
                            state_d     = ST_TWO;
                        end
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        main_fwd_d  = skid_fwd_q;
                        main_addr_d = skid_addr_q;
                        main_val_d  = skid_val_q;
                        main_pay_d  = skid_pay_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_EMPTY;
            main_fwd_q  <= 1'b0;
            main_addr_q <= '0;
            main_val_q  <= '0;
            main_pay_q  <= RESET_PAYLOAD;
            skid_fwd_q  <= 1'b0;
            skid_addr_q <= '0;
            skid_val_q  <= '0;
            skid_pay_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_fwd_q  <= main_fwd_d;
            main_addr_q <= main_addr_d;
            main_val_q  <= main_val_d;
            main_pay_q  <= main_pay_d;
            skid_fwd_q  <= skid_fwd_d;
            skid_addr_q <= skid_addr_d;
            skid_val_q  <= skid_val_d;
            skid_pay_q  <= skid_pay_d;
        end
    end

    assign out_forward = main_fwd_q;
    assign out_rd_addr = main_addr_q;
    assign out_rd_val  = main_val_q;
    assign out_payload = main_pay_q;
    assign fwd_valid   = (state_q != ST_EMPTY) && main_fwd_q;
    assign occupancy   = state_q;

`ifdef EPU_PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    // Saturating; flush deliberately leaves the count alone.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
module tb_pipe_skid_reg;

    localparam int unsigned     PW       = 42;
    localparam int unsigned     AW       = 5;
    localparam int unsigned     VW       = 32;
    localparam int unsigned     TB_CNT_W = 2;
    localparam logic [PW-1:0]   RST_PAY  = 42'h2A5_0000_0F0F;

    typedef struct {
        logic          fwd;
        logic [AW-1:0] addr;
        logic [VW-1:0] val;
        logic [PW-1:0] pay;
    } ent_t;

    logic          clk;
    logic          rst_in;
    logic          rdy_in;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic          in_forward;
    logic [AW-1:0] in_rd_addr;
    logic [VW-1:0] in_rd_val;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic          out_forward;
    logic [AW-1:0] out_rd_addr;
    logic [VW-1:0] out_rd_val;
    logic [PW-1:0] out_payload;
    logic          fwd_valid;
    logic [1:0]    occupancy;
`ifdef EPU_PIPE_PERF_EN
    logic [TB_CNT_W-1:0] stall_cycles;
`endif

    pipe_skid_reg #(
        .PAYLOAD_W     (PW),
        .RD_ADDR_W     (AW),
        .RD_VAL_W      (VW),
        .RESET_PAYLOAD (RST_PAY),
        .CNT_W         (TB_CNT_W)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_forward  (in_forward),
        .in_rd_addr  (in_rd_addr),
        .in_rd_val   (in_rd_val),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_forward (out_forward),
        .out_rd_addr (out_rd_addr),
        .out_rd_val  (out_rd_val),
        .out_payload (out_payload),
        .fwd_valid   (fwd_valid),
        .occupancy   (occupancy)
`ifdef EPU_PIPE_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    ent_t exp_q[$];          // reference FIFO: entries accepted, not yet delivered
    int   exp_stall = 0;
    bit   prev_rst = 1'b0;
    bit   prev_flush = 1'b0;
    int   nq;
    ent_t hd;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic f, input logic [AW-1:0] a,
                                input logic [VW-1:0] v, input logic [PW-1:0] p);
        ent_t e;
        e.fwd = f; e.addr = a; e.val = v; e.pay = p;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.fwd  = 1'($urandom_range(0, 1));
        e.addr = AW'($urandom());
        e.val  = $urandom();
        e.pay  = PW'({$urandom(), $urandom()});
        return e;
    endfunction

    // One clock cycle: apply inputs at posedge+1, record the accepted entry
    // just before the next edge, return at posedge+1 of the next cycle.
    task automatic drive(input logic r, input logic rdy, input logic fl,
                         input logic iv, input logic ordy, input ent_t e);
        rst_in = r; rdy_in = rdy; flush = fl; in_valid = iv; out_ready = ordy;
        in_forward = e.fwd; in_rd_addr = e.addr; in_rd_val = e.val; in_payload = e.pay;
        #6;
        if (in_valid && in_ready && !flush && !rst_in) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ent_t z;
        z = mk(1'b0, '0, '0, '0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, z);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, z);
    endtask

    // Monitor / scoreboard: compares the DUT against the FIFO model at every
    // falling edge, then retires whatever the coming rising edge transfers.
    always @(negedge clk) begin
        if (rst_in) begin
            exp_q.delete();
            exp_stall  = 0;
            prev_rst   = 1'b1;
            prev_flush = 1'b0;
        end else begin
            if (prev_rst) begin
                chk("rst_out_forward", out_forward, 0);
                chk("rst_out_rd_addr", out_rd_addr, 0);
                chk("rst_out_rd_val",  out_rd_val,  0);
                chk("rst_out_payload", out_payload, RST_PAY);
            end
            if (prev_flush) chk("flush_clears_forward", out_forward, 0);
            nq = exp_q.size();
            chk("in_ready",  in_ready,  (rdy_in && nq < 2) ? 1 : 0);
            chk("out_valid", out_valid, (rdy_in && nq > 0) ? 1 : 0);
            chk("occupancy", occupancy, nq);
            chk("fwd_valid", fwd_valid, (nq > 0 && exp_q[0].fwd) ? 1 : 0);
            if (nq > 0) begin
                hd = exp_q[0];
                chk("head_forward", out_forward, hd.fwd);
                chk("head_rd_addr", out_rd_addr, hd.addr);
                chk("head_rd_val",  out_rd_val,  hd.val);
                chk("head_payload", out_payload, hd.pay);
            end
`ifdef EPU_PIPE_PERF_EN
            chk("stall_cycles", stall_cycles, exp_stall);
            if (rdy_in && nq > 0 && !out_ready && exp_stall < (1 << TB_CNT_W) - 1)
                exp_stall++;
`endif
            if (flush) exp_q.delete();
            else if (rdy_in && nq > 0 && out_ready) void'(exp_q.pop_front());
            prev_rst   = 1'b0;
            prev_flush = flush;
        end
    end

    initial begin
        ent_t a, b, c, z;
        ent_t flow[8];
        z = mk(1'b0, '0, '0, '0);
        rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_forward = 1'b0; in_rd_addr = '0; in_rd_val = '0; in_payload = '0;
        @(posedge clk);
        #1;
        do_reset();
        chk("reset_occupancy", occupancy, 0);
        chk("reset_out_valid", out_valid, 0);

        // Single entry, one-cycle latency
        a = mk(1'b1, 5'd5, 32'h1234, 42'h3_0000_00AB);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        chk("lat_out_valid", out_valid, 1);
        chk("lat_rd_addr",   out_rd_addr, 5);
        chk("lat_rd_val",    out_rd_val, 32'h1234);
        chk("lat_fwd_valid", fwd_valid, 1);
        chk("lat_occupancy", occupancy, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, z);

        // Back-to-back with downstream stalled, then drain in order
        a = mk(1'b0, 5'd10, 32'hAAAA_0001, 42'h111);
        b = mk(1'b1, 5'd11, 32'hBBBB_0002, 42'h222);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, b);
        chk("skid_occupancy", occupancy, 2);
        chk("skid_in_ready",  in_ready, 0);
        chk("skid_head_a",    out_rd_addr, 10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, z);
        chk("drain_head_b",   out_rd_addr, 11);
        chk("drain_occ_1",    occupancy, 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, z);
        chk("drain_occ_0",    occupancy, 0);

        // Streaming: one entry per cycle, no bubbles
        for (int i = 0; i < 8; i++) begin
            flow[i] = rnd_ent();
            drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, flow[i]);
            chk("stream_out_valid", out_valid, 1);
            chk("stream_occupancy", occupancy, 1);
            chk("stream_head_val",  out_rd_val, flow[i].val);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, z);
        chk("stream_drained", occupancy, 0);

        // Flush in TWO while upstream offers an entry
        a = mk(1'b1, 5'd20, 32'h2020, 42'h20);
        b = mk(1'b1, 5'd21, 32'h2121, 42'h21);
        c = mk(1'b1, 5'd22, 32'h2222, 42'h22);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, b);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, c);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_fwd_valid", fwd_valid, 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z);
        chk("flush_no_capture", occupancy, 0);

        // Flush in ONE while in_ready is high: still nothing captured
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, c);
        chk("flush1_occupancy", occupancy, 0);

        // Freeze with one entry held
        a = mk(1'b1, 5'd7, 32'h7777, 42'h77);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, c);
            chk("freeze_in_ready",  in_ready, 0);
            chk("freeze_out_valid", out_valid, 0);
            chk("freeze_head",      out_rd_addr, 7);
            chk("freeze_fwd_valid", fwd_valid, 1);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z);
        chk("thaw_out_valid", out_valid, 1);
        chk("thaw_head",      out_rd_val, 32'h7777);

        // Reset while holding two entries
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, b);
        chk("pre_rst_occ", occupancy, 2);
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_occ",      occupancy, 0);

`ifdef EPU_PIPE_PERF_EN
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        chk("stall_start", stall_cycles, 0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, z);
            chk("stall_seq", stall_cycles, (i < 3) ? i + 1 : 3);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, z);
        chk("stall_after_flush", stall_cycles, 3);
        do_reset();
        chk("stall_after_reset", stall_cycles, 0);
`endif

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 1)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 3)  ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  rnd_ent());
        end

        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, z);
        chk("final_occupancy", occupancy, 0);
        chk("final_model_empty", exp_q.size(), 0);
        #6;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 42, width of the opaque payload (ins_type, ins_details and mem fields packed by the caller).
REQ-002 SHALL have parameter RD_ADDR_W, default 5, writeback register address width.
REQ-003 SHALL have parameter RD_VAL_W, default 32, writeback value width.
REQ-004 SHALL have parameter RESET_PAYLOAD, default 0, payload reset value.
REQ-005 SHALL have parameter CNT_W, default 16, stall counter width.
REQ-006 SHALL have port clk_in, input, 1, the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_in, input, 1, synchronous active-high reset.
REQ-008 SHALL have port rdy_in, input, 1, global enable; low means freeze.
REQ-009 SHALL have port flush, input, 1, discard all held entries.
REQ-010 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-011 SHALL have ports in_forward (input, 1), in_rd_addr (input, RD_ADDR_W), in_rd_val (input, RD_VAL_W) and in_payload (input, PAYLOAD_W), the upstream entry.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-013 SHALL have ports out_forward, out_rd_addr, out_rd_val and out_payload (outputs, widths as inputs), the head entry.
REQ-014 SHALL have port fwd_valid, output, 1, the forwarding tap: head entry is valid and carries forward=1.
REQ-015 SHALL have port occupancy, output, 2, number of held entries (0 to 2).

Function
REQ-016 SHALL hold up to two entries in registers: main (head) and skid; state is EMPTY, ONE or TWO.
REQ-017 SHALL drive in_ready = rdy_in and (state != TWO), and out_valid = rdy_in and (state != EMPTY).
REQ-018 SHALL count an input transfer only when in_valid and in_ready are both high, and an output transfer only when out_valid and out_ready are both high.
REQ-019 SHALL, in EMPTY, on an input transfer, load main and go to ONE.
REQ-020 SHALL, in ONE, on input and output transfers together, load main from the input and stay in ONE.
REQ-021 SHALL, in ONE, on an input transfer only, load skid and go to TWO.
REQ-022 SHALL, in ONE, on an output transfer only, go to EMPTY.
REQ-023 SHALL, in TWO, on an output transfer, copy skid to main and go to ONE; no input is accepted in TWO.
REQ-024 SHALL drive outputs directly from main registers with zero combinational path from in_* to out_*; latency from input transfer to out_valid is 1 cycle.
REQ-025 SHALL, when rdy_in=0, change no state and perform no transfer.
REQ-026 SHALL, when flush=1 (regardless of rdy_in), go to EMPTY, accept nothing, and clear main forward to 0; flush outranks any simultaneous transfer.
REQ-027 SHALL keep fwd_valid = (state != EMPTY) and main forward, independent of rdy_in.
REQ-028 SHALL never drop or duplicate an entry; order is preserved FIFO.

Reset
REQ-029 SHALL, on rst_in=1 at a clock edge, override flush and rdy_in and set: state EMPTY, out_forward 0, out_rd_addr 0, out_rd_val 0, out_payload RESET_PAYLOAD, skid contents 0, stall counter 0.
REQ-030 SHALL, on reset mid-operation (state TWO), discard both entries; in_ready returns high on the first cycle after reset is released if rdy_in=1.

Configuration
REQ-031 SHALL, with macro EPU_PIPE_PERF_EN defined, add output port stall_cycles (CNT_W) that increments when out_valid=1 and out_ready=0, saturates at all-ones, clears on reset only (not on flush).
REQ-032 SHALL, without EPU_PIPE_PERF_EN defined, omit the stall_cycles port and its counter entirely; all other behaviour is identical.

Verification
REQ-033 SHALL cover: reset, then in_valid=1 with rd_addr=5, rd_val=0x1234, forward=1 -> next cycle out_valid=1, out_rd_addr=5, out_rd_val=0x1234, fwd_valid=1, occupancy=1.
REQ-034 SHALL cover: out_ready=0 with entries A and B sent back-to-back -> occupancy=2 and in_ready=0; then out_ready=1 -> A, then B delivered in order on consecutive cycles.
REQ-035 SHALL cover: steady in_valid=1 and out_ready=1 over 8 entries -> one entry delivered per cycle, occupancy stays 1, no bubbles.
REQ-036 SHALL cover: state TWO with flush=1 while in_valid=1 -> next cycle occupancy=0, out_valid=0, fwd_valid=0, and the input is not captured.
REQ-037 SHALL cover: rdy_in=0 for 3 cycles with state ONE -> outputs unchanged and in_ready=out_valid=0; when rdy_in returns high, the same entry is presented.
REQ-038 SHALL cover: with EPU_PIPE_PERF_EN and CNT_W=2, out_ready held 0 for 5 cycles with an entry held -> stall_cycles reads 1, 2, 3, 3, 3; flush leaves it at 3; reset clears it to 0.
